// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU load/store data path.
// Holds the responder FSM state encodings and the access-size constants.
// Also holds the decode helpers (lane select, byte enables, fault check),
// which the ldr_str decode in the core can reuse.
package cpu_mem_pkg;

  // Responder FSM state encodings; 2'd3 is illegal.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Access size as carried by the B bit of LDR/STR.
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // Zero-extended little-endian byte from a 32-bit word.
  function automatic logic [31:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] res;
    case (lane)
      2'd0:    res = {24'd0, word[7:0]};
      2'd1:    res = {24'd0, word[15:8]};
      2'd2:    res = {24'd0, word[23:16]};
      2'd3:    res = {24'd0, word[31:24]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Byte write enables for an access of the given size at the given lane.
  function automatic logic [3:0] byte_enables(input logic size, input logic [1:0] lane);
    logic [3:0] be;
    if (size == SIZE_WORD) begin
      be = 4'b1111;
    end else begin
      be = 4'b0001 << lane;
    end
    return be;
  endfunction

  // Address fault: any decoded-out upper bit set, or a word access off a word boundary.
  function automatic logic addr_fault(input logic [31:0] addr, input logic size, input int aw);
    logic out_of_range;
    logic misaligned;
    out_of_range = ((addr >> aw) != 32'd0);
    misaligned   = (size == SIZE_WORD) && (addr[1:0] != 2'd0);
    return out_of_range | misaligned;
  endfunction

endpackage

// File: rtl/sp_ram_bytewe.sv
// Single-port synchronous RAM, 32-bit words, with per-byte write enables.
// Reads return the contents as they were before any write on the same edge.
// Ports:
//   clk    - clock
//   en     - access strobe; rdata updates only on enabled edges
//   we     - byte write enables, bit i covers wdata[8*i+7:8*i]
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read data
module sp_ram_bytewe #(
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [3:0]           we,
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem_r [2**IDX_WIDTH];

  // Storage write and registered read; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem_r[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata <= mem_r[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the CPU load/store data interface.
// It accepts one LDR/STR/LDRB/STRB request and waits LATENCY cycles.
// It then performs the access on the internal RAM and holds the response
// until the CPU takes it.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_write, req_byte   - store / byte-access qualifiers
//   req_addr, req_wdata   - byte address and store data
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata, rsp_err    - load data (0 for stores/errors), fault flag
//   debug_state           - current FSM state
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  debug_state
);

  localparam int         IDX_WIDTH = ADDR_WIDTH - 2;
  localparam logic [3:0] LAT_LOAD  = 4'(LATENCY);

  logic [1:0]  state_r;
  logic [1:0]  next_state_s;
  logic [3:0]  count_r;
  logic        write_r;
  logic        byte_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        accept_s;
  logic        access_s;
  logic        acc_write_s;
  logic        acc_byte_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic        acc_fault_s;
  logic [3:0]  ram_we_s;
  logic [31:0] ram_wdata_s;
  logic [31:0] ram_rdata_s;
  logic        rsp_fault_s;

  assign accept_s    = req_valid & req_ready;
  assign debug_state = state_r;

  // RAM access strobe: last WAIT cycle, or the accept edge itself when there is no wait.
  always_comb begin
    access_s = 1'b0;
    if (reset) begin
      access_s = 1'b0;
    end else if ((state_r == WAIT) && (count_r <= 4'd1)) begin
      access_s = 1'b1;
    end else if ((LATENCY == 0) && accept_s) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
  end

  // Access operands: the live request only in the zero-latency IDLE case, else the latched copy.
  always_comb begin
    acc_write_s = write_r;
    acc_byte_s  = byte_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      acc_write_s = req_write;
      acc_byte_s  = req_byte;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_write_s = write_r;
      acc_byte_s  = byte_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  assign acc_fault_s = addr_fault(acc_addr_s, acc_byte_s, ADDR_WIDTH);
  // Byte stores replicate the low byte to every lane; the enables pick the one that lands.
  assign ram_wdata_s = (acc_byte_s == SIZE_BYTE) ? {4{acc_wdata_s[7:0]}} : acc_wdata_s;
  assign ram_we_s    = (access_s && acc_write_s && !acc_fault_s)
                       ? byte_enables(acc_byte_s, acc_addr_s[1:0]) : 4'b0000;

  sp_ram_bytewe #(
    .IDX_WIDTH(IDX_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (access_s),
    .we   (ram_we_s),
    .idx  (acc_addr_s[ADDR_WIDTH-1:2]),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; the illegal encoding falls back to IDLE.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = (LATENCY == 0) ? RESP : WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (count_r <= 4'd1) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Request latch and wait counter; the counter only counts down from a loaded value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 4'd0;
      write_r <= 1'b0;
      byte_r  <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      count_r <= LAT_LOAD;
      write_r <= req_write;
      byte_r  <= req_byte;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end else if ((state_r == WAIT) && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign rsp_fault_s = addr_fault(addr_r, byte_r, ADDR_WIDTH);

  // FSM outputs; response fields derive from the latched request and the registered RAM word.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = !reset;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_fault_s) begin
          rsp_err = 1'b1;
        end else if (!write_r) begin
          rsp_rdata = (byte_r == SIZE_BYTE) ? lane_select(ram_rdata_s, addr_r[1:0]) : ram_rdata_s;
        end else begin
          rsp_rdata = 32'd0;
        end
      end
      default: begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at LATENCY=2 (index 0) and one at
// LATENCY=0 (index 1). Stimulus pushes the expected response into a per-DUT queue.
// A monitor pops and compares on every response handshake.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       [2];
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_write   [2];
  logic        req_byte    [2];
  logic [31:0] req_addr    [2];
  logic [31:0] req_wdata   [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [31:0] rsp_rdata   [2];
  logic        rsp_err     [2];
  logic [1:0]  debug_state [2];

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_byte(req_byte[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .debug_state(debug_state[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_byte(req_byte[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .debug_state(debug_state[1])
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare every accepted response against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1 && rsp_ready[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp dut%0d: got response rdata 0x%08h, required none", d, rsp_rdata[d]);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("rsp_rdata dut%0d", d), rsp_rdata[d], e.rdata);
          check($sformatf("rsp_err dut%0d", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
        end
      end
    end
  end

  // One transaction on DUT d; called and returning at a falling edge.
  task automatic xact(input int d, input logic wr, input logic by, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold, input bit poke);
    int   n;
    exp_t e;
    rsp_ready[d] = (hold == 0);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("req_ready_before dut%0d", d), {31'd0, req_ready[d]}, 32'd1);
    e.err   = exp_err;
    e.rdata = exp_rdata;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    req_write[d] = wr;
    req_byte[d]  = by;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid[d] !== 1'b1 && n < 40);
    check($sformatf("rsp_latency dut%0d @%0h", d, addr), 32'(n), (d == 0) ? 32'd3 : 32'd1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clk);
        check($sformatf("hold_valid dut%0d c%0d", d, i), {31'd0, rsp_valid[d]}, 32'd1);
        check($sformatf("hold_rdata dut%0d c%0d", d, i), rsp_rdata[d], exp_rdata);
        check($sformatf("hold_err dut%0d c%0d", d, i), {31'd0, rsp_err[d]}, {31'd0, exp_err});
        check($sformatf("hold_req_ready dut%0d c%0d", d, i), {31'd0, req_ready[d]}, 32'd0);
        if (poke) begin
          if (i == 0) begin
            req_write[d] = 1'b1;
            req_wdata[d] = 32'hFFFF_FFFF;
            req_valid[d] = 1'b1;
          end else begin
            req_valid[d] = 1'b0;
          end
        end
      end
      req_valid[d] = 1'b0;
      @(posedge clk);
      #1 rsp_ready[d] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check($sformatf("idle_req_ready dut%0d", d), {31'd0, req_ready[d]}, 32'd1);
    check($sformatf("idle_rsp_valid dut%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  task automatic check_reset_outputs(input int d);
    check($sformatf("rst_req_ready dut%0d", d), {31'd0, req_ready[d]}, 32'd0);
    check($sformatf("rst_rsp_valid dut%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
    check($sformatf("rst_rsp_rdata dut%0d", d), rsp_rdata[d], 32'd0);
    check($sformatf("rst_rsp_err dut%0d", d), {31'd0, rsp_err[d]}, 32'd0);
    check($sformatf("rst_state dut%0d", d), {30'd0, debug_state[d]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_byte[d]  = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);

    // LATENCY=2 instance
    xact(0, 1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0);
    xact(0, 1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h10,  32'h11223344, 32'h0,        1'b0, 0, 1'b0);
    xact(0, 1'b1, 1'b1, 32'h13,  32'h123456AA, 32'h0,        1'b0, 0, 1'b0);
    xact(0, 1'b0, 1'b0, 32'h10,  32'h0,        32'hAA223344, 1'b0, 0, 1'b0);
    xact(0, 1'b0, 1'b1, 32'h12,  32'h0,        32'h00000022, 1'b0, 0, 1'b0);
    xact(0, 1'b0, 1'b1, 32'h11,  32'h0,        32'h00000033, 1'b0, 0, 1'b0);
    xact(0, 1'b0, 1'b1, 32'h13,  32'h0,        32'h000000AA, 1'b0, 0, 1'b0);
    xact(0, 1'b0, 1'b0, 32'h06,  32'h0,        32'h0,        1'b1, 0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h0,   32'h0BADF00D, 32'h0,        1'b0, 0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0,        1'b1, 0, 1'b0);
    xact(0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0, 0, 1'b0);
    xact(0, 1'b0, 1'b0, 32'h10,  32'h0,        32'hAA223344, 1'b0, 5, 1'b0);

    // Reset in the last WAIT cycle of a store must abandon it
    xact(0, 1'b1, 1'b0, 32'h20,  32'h12345678, 32'h0,        1'b0, 0, 1'b0);
    req_write[0] = 1'b1;
    req_byte[0]  = 1'b0;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h00000055;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("wait_state dut0", {30'd0, debug_state[0]}, 32'd1);
    @(posedge clk);
    #1 reset[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk);
    #1 reset[0] = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready dut0", {31'd0, req_ready[0]}, 32'd1);
    xact(0, 1'b0, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0, 0, 1'b0);

    // LATENCY=0 instance
    xact(1, 1'b1, 1'b0, 32'h40,  32'h5A5A1234, 32'h0,        1'b0, 0, 1'b0);
    xact(1, 1'b0, 1'b0, 32'h40,  32'h0,        32'h5A5A1234, 1'b0, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("no_extra_rsp dut1 c%0d", i), {31'd0, rsp_valid[1]}, 32'd0);
    end
    xact(1, 1'b0, 1'b0, 32'h40,  32'h0,        32'h5A5A1234, 1'b0, 0, 1'b0);
    xact(1, 1'b1, 1'b1, 32'h41,  32'h00000077, 32'h0,        1'b0, 0, 1'b0);
    xact(1, 1'b0, 1'b0, 32'h40,  32'h0,        32'h5A5A7734, 1'b0, 0, 1'b0);
    xact(1, 1'b0, 1'b0, 32'h02,  32'h0,        32'h0,        1'b1, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("pending_responses", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
